// File: rtl/neorv32_irq_ctrl.sv
// neorv32_irq_ctrl: external interrupt aggregator with claim handshake
// and periodic machine-timer tick generator.
module neorv32_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '1,
  parameter int TICK_DIV = 100000,
  localparam int IDW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               claim_i,
  output logic               ext_irq,
  output logic [IDW-1:0]     irq_id,
  output logic               overflow_o,
  input  logic               tick_en_i,
  input  logic               tick_ack_i,
  output logic               time_irq,
  output logic               tick_miss_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(TICK_DIV - 1);
  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_GAP
  } state_e;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic               ovf_q, ovf_d;

  state_e             state_q, state_d;
  logic               ext_q, ext_d;
  logic [IDW-1:0]     id_q, id_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               time_q, time_d;
  logic               miss_q, miss_d;

  logic [NUM_SRC-1:0] synced;
  logic [NUM_SRC-1:0] edge_v;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] eligible;
  logic               any_elig;
  logic [IDW-1:0]     winner;
  logic               win_found;
  logic               id_mask;
  logic               wrap;

  // Synchronizer shift, previous-sample capture and post-reset warm-up.
  // Edges are ignored until the chain and prev_q hold real samples, so a
  // source already high at reset release is not mistaken for an edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
    synced = sync_q[SYNC_STAGES-1];
    prev_d = synced;
    warm_d = warm_q;
    if (warm_q != WARM_DONE) begin
      warm_d = warm_q + WW'(1);
    end
    edge_v = synced & ~prev_q & EDGE_MASK;
    if (warm_q != WARM_DONE) begin
      edge_v = '0;
    end
  end

  // Claim decode, pending update and overflow detection.
  always_comb begin
    claim_vec = '0;
    pend_d    = pend_q;
    ovf_d     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == S_ASSERT && claim_i && id_q == IDW'(i)) begin
        claim_vec[i] = 1'b1;
      end
      if (EDGE_MASK[i]) begin
        if (edge_v[i]) begin
          pend_d[i] = 1'b1;
          if (pend_q[i] && !claim_vec[i]) begin
            ovf_d = 1'b1;
          end
        end else if (claim_vec[i]) begin
          pend_d[i] = 1'b0;
        end
      end else begin
        pend_d[i] = synced[i];
      end
    end
  end

  // Fixed priority: lowest eligible index wins; also look up the mask of
  // the source currently being signalled.
  always_comb begin
    eligible  = pend_q & mask_i;
    any_elig  = |eligible;
    winner    = '0;
    win_found = 1'b0;
    id_mask   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eligible[i] && !win_found) begin
        winner    = IDW'(i);
        win_found = 1'b1;
      end
      if (id_q == IDW'(i)) begin
        id_mask = mask_i[i];
      end
    end
  end

  // Request FSM: IDLE -> ASSERT on any eligible, ASSERT -> GAP on claim or
  // withdraw, GAP forces one low cycle before the next request.
  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    id_d    = id_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_elig) begin
          id_d    = winner;
          ext_d   = 1'b1;
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (claim_i || !id_mask) begin
          ext_d   = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        ext_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Tick counter with sticky time_irq; ack at the wrap loses to the wrap.
  always_comb begin
    wrap   = tick_en_i && (cnt_q == CNT_TOP);
    cnt_d  = '0;
    time_d = time_q;
    miss_d = 1'b0;
    if (tick_en_i && !wrap) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (wrap) begin
      time_d = 1'b1;
      miss_d = time_q && !tick_ack_i;
    end else if (tick_ack_i) begin
      time_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      warm_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
      ext_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      time_q  <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      warm_q  <= warm_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      ext_q   <= ext_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      miss_q  <= miss_d;
    end
  end

  assign ext_irq     = ext_q;
  assign irq_id      = id_q;
  assign overflow_o  = ovf_q;
  assign time_irq    = time_q;
  assign tick_miss_o = miss_q;

endmodule

// File: tb/tb_neorv32_irq_ctrl.sv
// tb_neorv32_irq_ctrl: scenario tasks plus randomized checks against
// a queue/arithmetic reference of the interrupt and tick behaviour.
module tb_neorv32_irq_ctrl;

  localparam int N  = 8;
  localparam int TD = 10;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] src_i;
  logic [N-1:0] mask_i;
  logic         claim_i;
  logic         ext_irq;
  logic [2:0]   irq_id;
  logic         overflow_o;
  logic         tick_en_i;
  logic         tick_ack_i;
  logic         time_irq;
  logic         tick_miss_o;

  int n_checks = 0;
  int n_fail   = 0;

  neorv32_irq_ctrl #(
    .NUM_SRC(N),
    .SYNC_STAGES(2),
    .TICK_DIV(TD)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .src_i(src_i),
    .mask_i(mask_i),
    .claim_i(claim_i),
    .ext_irq(ext_irq),
    .irq_id(irq_id),
    .overflow_o(overflow_o),
    .tick_en_i(tick_en_i),
    .tick_ack_i(tick_ack_i),
    .time_irq(time_irq),
    .tick_miss_o(tick_miss_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_i = '0;
    mask_i = '1;
    claim_i = 1'b0;
    tick_en_i = 1'b0;
    tick_ack_i = 1'b0;
    step();
    step();
    n_checks++;
    if ({ext_irq, irq_id, overflow_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ext: got %b want 00000",
               {ext_irq, irq_id, overflow_o});
    end
    n_checks++;
    if ({time_irq, tick_miss_o} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_tick: got %b want 00",
               {time_irq, tick_miss_o});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_single();
    src_i[3] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_checks++;
      if (ext_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early k=%0d: got %b want 0", k, ext_irq);
      end
    end
    step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd3) begin
      n_fail++;
      $display("FAIL single_assert: got ext=%b id=%0d want ext=1 id=3",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    n_checks++;
    if (ext_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL single_claim: got %b want 0", ext_irq);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (ext_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL single_rereq k=%0d: got %b want 0", k, ext_irq);
      end
    end
    src_i[3] = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_priority();
    src_i[5] = 1'b1;
    src_i[2] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd2) begin
      n_fail++;
      $display("FAIL prio_first: got ext=%b id=%0d want ext=1 id=2",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      n_checks++;
      if (ext_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_gap k=%0d: got %b want 0", k, ext_irq);
      end
      step();
    end
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd5) begin
      n_fail++;
      $display("FAIL prio_second: got ext=%b id=%0d want ext=1 id=5",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (ext_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_drain: got %b want 0", ext_irq);
    end
    src_i = '0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_overflow();
    int pulses;
    src_i[1] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd1) begin
      n_fail++;
      $display("FAIL ovf_assert: got ext=%b id=%0d want ext=1 id=1",
               ext_irq, irq_id);
    end
    src_i[1] = 1'b0;
    step();
    step();
    src_i[1] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (overflow_o === 1'b1) pulses++;
      n_checks++;
      if (ext_irq !== 1'b1 || irq_id !== 3'd1) begin
        n_fail++;
        $display("FAIL ovf_hold k=%0d: got ext=%b id=%0d want ext=1 id=1",
                 k, ext_irq, irq_id);
      end
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL ovf_pulses: got %0d want 1", pulses);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      n_checks++;
      if (ext_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_rereq k=%0d: got %b want 0", k, ext_irq);
      end
    end
    src_i[1] = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_mask_withdraw();
    src_i[4] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd4) begin
      n_fail++;
      $display("FAIL wd_assert: got ext=%b id=%0d want ext=1 id=4",
               ext_irq, irq_id);
    end
    mask_i[4] = 1'b0;
    step();
    n_checks++;
    if (ext_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_drop: got %b want 0", ext_irq);
    end
    mask_i[4] = 1'b1;
    step();
    n_checks++;
    if (ext_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_gap: got %b want 0", ext_irq);
    end
    step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd4) begin
      n_fail++;
      $display("FAIL wd_reassert: got ext=%b id=%0d want ext=1 id=4",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    src_i[4] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    src_i[7] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd7) begin
      n_fail++;
      $display("FAIL cw_assert: got ext=%b id=%0d want ext=1 id=7",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    mask_i[7] = 1'b0;
    step();
    claim_i = 1'b0;
    mask_i[7] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (ext_irq !== 1'b0) begin
        n_fail++;
        $display("FAIL cw_claim_wins k=%0d: got %b want 0", k, ext_irq);
      end
      step();
    end
    src_i[7] = 1'b0;
    for (int k = 0; k < 3; k++) step();
  endtask

  task automatic test_random_irq();
    logic [N-1:0] subset;
    logic [N-1:0] m;
    logic [2:0]   order[$];
    int           n_en;
    int           hold;
    for (int it = 0; it < 16; it++) begin
      subset = N'($urandom_range(1, 255));
      m      = N'($urandom_range(0, 255));
      order.delete();
      n_en = 0;
      for (int i = 0; i < N; i++) begin
        if (subset[i] && m[i]) begin
          order.push_back(3'(i));
          n_en++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (subset[i] && !m[i]) order.push_back(3'(i));
      end
      mask_i = m;
      src_i  = subset;
      for (int k = 0; k < 4; k++) step();
      if (n_en == 0) begin
        n_checks++;
        if (ext_irq !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_masked it=%0d: got %b want 0", it, ext_irq);
        end
        mask_i = '1;
        step();
      end
      for (int j = 0; j < order.size(); j++) begin
        n_checks++;
        if (ext_irq !== 1'b1 || irq_id !== order[j]) begin
          n_fail++;
          $display("FAIL rnd_serve it=%0d j=%0d: got ext=%b id=%0d want ext=1 id=%0d",
                   it, j, ext_irq, irq_id, order[j]);
        end
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
          step();
          n_checks++;
          if (ext_irq !== 1'b1 || irq_id !== order[j] || overflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_hold it=%0d: got ext=%b id=%0d ovf=%b want 1 %0d 0",
                     it, ext_irq, irq_id, overflow_o, order[j]);
          end
        end
        claim_i = 1'b1;
        step();
        claim_i = 1'b0;
        n_checks++;
        if (ext_irq !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_claim it=%0d: got %b want 0", it, ext_irq);
        end
        step();
        n_checks++;
        if (ext_irq !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_gap it=%0d: got %b want 0", it, ext_irq);
        end
        if (j + 1 == n_en) mask_i = '1;
        step();
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (ext_irq !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_quiet it=%0d: got %b want 0", it, ext_irq);
        end
        step();
      end
      src_i  = '0;
      mask_i = '1;
      for (int k = 0; k < 4; k++) step();
    end
  endtask

  task automatic test_tick_basic();
    tick_en_i = 1'b1;
    for (int k = 1; k <= 9; k++) step();
    n_checks++;
    if (time_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_early: got %b want 0", time_irq);
    end
    step();
    n_checks++;
    if (time_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_first: got %b want 1", time_irq);
    end
    for (int k = 11; k <= 19; k++) step();
    n_checks++;
    if (tick_miss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_nomiss: got %b want 0", tick_miss_o);
    end
    step();
    n_checks++;
    if (tick_miss_o !== 1'b1 || time_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_miss: got miss=%b time=%b want 1 1",
               tick_miss_o, time_irq);
    end
    step();
    n_checks++;
    if (tick_miss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_miss_end: got %b want 0", tick_miss_o);
    end
    for (int k = 22; k <= 29; k++) step();
    tick_ack_i = 1'b1;
    step();
    tick_ack_i = 1'b0;
    n_checks++;
    if (time_irq !== 1'b1 || tick_miss_o !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_ack_wrap: got time=%b miss=%b want 1 0",
               time_irq, tick_miss_o);
    end
    tick_ack_i = 1'b1;
    step();
    tick_ack_i = 1'b0;
    n_checks++;
    if (time_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL tick_ack: got %b want 0", time_irq);
    end
    tick_en_i = 1'b0;
    step();
  endtask

  task automatic test_tick_random();
    int cnt = 0;
    bit tirq = 1'b0;
    bit wrap;
    bit exp_miss;
    bit en;
    bit ack;
    for (int c = 0; c < 150; c++) begin
      en  = ($urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 5) == 0);
      tick_en_i  = en;
      tick_ack_i = ack;
      wrap     = en && (cnt == TD - 1);
      exp_miss = wrap && tirq && !ack;
      if (wrap) tirq = 1'b1;
      else if (ack) tirq = 1'b0;
      cnt = !en ? 0 : (wrap ? 0 : cnt + 1);
      step();
      n_checks++;
      if (time_irq !== tirq || tick_miss_o !== exp_miss) begin
        n_fail++;
        $display("FAIL tick_rnd c=%0d: got time=%b miss=%b want %b %b",
                 c, time_irq, tick_miss_o, tirq, exp_miss);
      end
    end
    tick_en_i  = 1'b0;
    tick_ack_i = 1'b1;
    step();
    tick_ack_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    src_i[6]  = 1'b1;
    tick_en_i = 1'b1;
    for (int k = 0; k < 10; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd6 || time_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got ext=%b id=%0d time=%b want 1 6 1",
               ext_irq, irq_id, time_irq);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ext_irq, irq_id, overflow_o, time_irq, tick_miss_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL rmid_async: got %b want 0000000",
               {ext_irq, irq_id, overflow_o, time_irq, tick_miss_o});
    end
    tick_en_i = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ext_irq !== 1'b0) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL rmid_spurious: got %0d high cycles want 0", pulses);
    end
    src_i[6] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    src_i[6] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    n_checks++;
    if (ext_irq !== 1'b1 || irq_id !== 3'd6) begin
      n_fail++;
      $display("FAIL rmid_after: got ext=%b id=%0d want ext=1 id=6",
               ext_irq, irq_id);
    end
    claim_i = 1'b1;
    step();
    claim_i = 1'b0;
    src_i = '0;
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_mask_withdraw();
    test_random_irq();
    test_tick_basic();
    test_tick_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
